// File: rtl/pipeline_control_pkg.sv
// Shared types for the RV32I pipeline hazard/stall controller.
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_HOLD = 2'd2
  } pipe_ctrl_state_t;

  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Central hazard/stall controller for the 5-stage RV32I pipeline, with
// saturating stall/bubble/flush performance counters.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_to_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_to_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_to_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_to_id_rs2,
  input  logic                  if_to_id_use_rs1,
  input  logic                  if_to_id_use_rs2,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  ex_br_taken,
  input  logic                  ex_mc_op,
  input  logic                  mc_done,
  output logic                  mc_start,
  output logic                  pc_load,
  output logic                  if_id_load,
  output logic                  id_ex_load,
  output logic                  ex_mem_load,
  output logic                  mem_wb_load,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  pipe_ctrl_state_t state, next_state;
  logic mc_ready, mc_ready_next;
  logic mem_stall, load_use;
  logic stall_ev, bubble_ev, flush_ev;
  logic [4:0] loads;

  assign mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
  assign load_use  = id_to_ex_mem_read && (id_to_ex_rd != '0) &&
                     ((if_to_id_use_rs1 && (id_to_ex_rd == if_to_id_rs1)) ||
                      (if_to_id_use_rs2 && (id_to_ex_rd == if_to_id_rs2)));

  assign {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = loads;

  // mc_ready marks a finished mc op still sitting in EX, so the RUN cycle
  // after mc_done advances it instead of relaunching the unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      mc_ready <= 1'b0;
    end else begin
      state    <= next_state;
      mc_ready <= mc_ready_next;
    end
  end

  always_comb begin
    next_state    = state;
    mc_ready_next = mc_ready;
    mc_start      = 1'b0;
    loads         = 5'b00000;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    stall_ev      = 1'b0;
    bubble_ev     = 1'b0;
    flush_ev      = 1'b0;
    if (!rst) begin
      if (mem_stall || (state == MC_WAIT)) begin
        stall_ev = 1'b1;
        if ((state == MC_WAIT) && mc_done) begin
          next_state    = mem_stall ? MC_HOLD : RUN;
          mc_ready_next = 1'b1;
        end
      end else if (mc_ready) begin
        loads         = 5'b11111;
        mc_ready_next = 1'b0;
        next_state    = RUN;
      end else if ((state == RUN) && ex_mc_op) begin
        mc_start   = 1'b1;
        stall_ev   = 1'b1;
        next_state = MC_WAIT;
      end else if (ex_br_taken) begin
        loads       = 5'b11111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_ev    = 1'b1;
      end else if (load_use) begin
        loads       = 5'b00111;
        id_ex_flush = 1'b1;
        bubble_ev   = 1'b1;
      end else begin
        loads = 5'b11111;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_ev), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(bubble_ev), .count(bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_ev), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed hazard scenarios plus a
// randomized run against a behavioural model of the stall/bubble/flush rules.
module tb_pipeline_control;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control vector order: {mc_start, pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [7:0] FREEZE   = 8'b0_00000_00;
  localparam logic [7:0] LAUNCH   = 8'b1_00000_00;
  localparam logic [7:0] ALL_LOAD = 8'b0_11111_00;
  localparam logic [7:0] REDIRECT = 8'b0_11111_11;
  localparam logic [7:0] BUBBLE   = 8'b0_00111_01;

  logic clk, rst;
  logic id_to_ex_mem_read;
  logic [4:0] id_to_ex_rd, if_to_id_rs1, if_to_id_rs2;
  logic if_to_id_use_rs1, if_to_id_use_rs2;
  logic imem_req, imem_resp, dmem_req, dmem_resp;
  logic ex_br_taken, ex_mc_op, mc_done;
  logic mc_start, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [7:0] ctrl;

  int n_compared = 0;
  int n_failed   = 0;

  pipeline_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_to_ex_mem_read(id_to_ex_mem_read), .id_to_ex_rd(id_to_ex_rd),
    .if_to_id_rs1(if_to_id_rs1), .if_to_id_rs2(if_to_id_rs2),
    .if_to_id_use_rs1(if_to_id_use_rs1), .if_to_id_use_rs2(if_to_id_use_rs2),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_br_taken(ex_br_taken), .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .mc_start(mc_start), .pc_load(pc_load), .if_id_load(if_id_load),
    .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {mc_start, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                 if_id_flush, id_ex_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    id_to_ex_mem_read = 1'b0; id_to_ex_rd = 5'd0;
    if_to_id_rs1 = 5'd0; if_to_id_rs2 = 5'd0;
    if_to_id_use_rs1 = 1'b0; if_to_id_use_rs2 = 1'b0;
    imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_br_taken = 1'b0; ex_mc_op = 1'b0; mc_done = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_lw_hazard(input logic [4:0] rd);
    id_to_ex_mem_read = 1'b1; id_to_ex_rd = rd;
    if_to_id_rs1 = 5'd7; if_to_id_use_rs1 = 1'b1;
    if_to_id_rs2 = rd;   if_to_id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_to_ex_mem_read = 1'b1; id_to_ex_rd = 5'd3; if_to_id_rs1 = 5'd3;
      if_to_id_use_rs1 = 1'b1; ex_br_taken = $urandom % 2; ex_mc_op = $urandom % 2;
      @(negedge clk);
      n_compared++;
      if (ctrl !== FREEZE) begin
        n_failed++; $display("[TB] FAIL reset_ctrl: got %b want %b", ctrl, FREEZE);
      end
      n_compared++;
      if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
        n_failed++; $display("[TB] FAIL reset_cnt: got %h/%h/%h want 0", stall_cnt, bubble_cnt, flush_cnt);
      end
      next_cycle();
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_lw_hazard(5'd5);
    @(negedge clk);
    n_compared++;
    if (ctrl !== BUBBLE) begin
      n_failed++; $display("[TB] FAIL load_use_bubble: got %b want %b", ctrl, BUBBLE);
    end
    next_cycle();
    id_to_ex_mem_read = 1'b0;
    @(negedge clk);
    n_compared++;
    if (ctrl !== ALL_LOAD) begin
      n_failed++; $display("[TB] FAIL load_use_after: got %b want %b", ctrl, ALL_LOAD);
    end
    n_compared++;
    if (bubble_cnt !== 8'd1) begin
      n_failed++; $display("[TB] FAIL load_use_cnt: got %0d want 1", bubble_cnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_no_bubble();
    do_reset();
    set_lw_hazard(5'd0);
    @(negedge clk);
    n_compared++;
    if (ctrl !== ALL_LOAD) begin
      n_failed++; $display("[TB] FAIL no_bubble_x0: got %b want %b", ctrl, ALL_LOAD);
    end
    next_cycle();
    set_lw_hazard(5'd5);
    if_to_id_use_rs2 = 1'b0;
    @(negedge clk);
    n_compared++;
    if (ctrl !== ALL_LOAD) begin
      n_failed++; $display("[TB] FAIL no_bubble_unused: got %b want %b", ctrl, ALL_LOAD);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_compared++;
    if (bubble_cnt !== 8'd0) begin
      n_failed++; $display("[TB] FAIL no_bubble_cnt: got %0d want 0", bubble_cnt);
    end
    next_cycle();
  endtask

  task automatic test_imem_stall();
    do_reset();
    imem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (ctrl !== FREEZE) begin
        n_failed++; $display("[TB] FAIL imem_stall_%0d: got %b want %b", i, ctrl, FREEZE);
      end
      next_cycle();
    end
    imem_resp = 1'b1;
    @(negedge clk);
    n_compared++;
    if (ctrl !== ALL_LOAD) begin
      n_failed++; $display("[TB] FAIL imem_resp: got %b want %b", ctrl, ALL_LOAD);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_compared++;
    if (stall_cnt !== 8'd3) begin
      n_failed++; $display("[TB] FAIL imem_stall_cnt: got %0d want 3", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_branch_vs_load_use();
    do_reset();
    set_lw_hazard(5'd9);
    ex_br_taken = 1'b1;
    @(negedge clk);
    n_compared++;
    if (ctrl !== REDIRECT) begin
      n_failed++; $display("[TB] FAIL branch_redirect: got %b want %b", ctrl, REDIRECT);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_compared++;
    if ({flush_cnt, bubble_cnt} !== {8'd1, 8'd0}) begin
      n_failed++; $display("[TB] FAIL branch_cnts: got flush=%0d bubble=%0d want 1/0", flush_cnt, bubble_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mc_op();
    logic [7:0] want;
    int starts = 0;
    do_reset();
    ex_mc_op = 1'b1;
    // Cycle 0 launch, 1..4 waiting (done on 4), 5..6 dmem stall, 7 advance.
    for (int c = 0; c < 8; c++) begin
      mc_done   = (c == 4) || (c == 5);
      dmem_req  = (c >= 4);
      dmem_resp = (c == 7);
      want = (c == 0) ? LAUNCH : (c == 7) ? ALL_LOAD : FREEZE;
      @(negedge clk);
      if (mc_start === 1'b1) starts++;
      n_compared++;
      if (ctrl !== want) begin
        n_failed++; $display("[TB] FAIL mc_hold_c%0d: got %b want %b", c, ctrl, want);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_compared++;
    if (starts !== 1) begin
      n_failed++; $display("[TB] FAIL mc_start_pulses: got %0d want 1", starts);
    end
    n_compared++;
    if (stall_cnt !== 8'd7) begin
      n_failed++; $display("[TB] FAIL mc_hold_stall_cnt: got %0d want 7", stall_cnt);
    end
    next_cycle();
    // Without memory stall: launch, done on cycle 4, advance on cycle 5.
    ex_mc_op = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mc_done = (c == 4);
      want = (c == 0) ? LAUNCH : (c == 5) ? ALL_LOAD : FREEZE;
      @(negedge clk);
      n_compared++;
      if (ctrl !== want) begin
        n_failed++; $display("[TB] FAIL mc_run_c%0d: got %b want %b", c, ctrl, want);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_compared++;
    if (stall_cnt !== 8'd12) begin
      n_failed++; $display("[TB] FAIL mc_run_stall_cnt: got %0d want 12", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      if (i == CNT_MAX - 1) begin
        @(negedge clk);
        n_compared++;
        if (stall_cnt !== 8'(CNT_MAX - 1)) begin
          n_failed++; $display("[TB] FAIL sat_pre: got %0d want %0d", stall_cnt, CNT_MAX - 1);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    n_compared++;
    if (stall_cnt !== 8'(CNT_MAX)) begin
      n_failed++; $display("[TB] FAIL sat_hold: got %0d want %0d", stall_cnt, CNT_MAX);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_mc();
    do_reset();
    ex_mc_op = 1'b1;
    @(negedge clk);
    n_compared++;
    if (ctrl !== LAUNCH) begin
      n_failed++; $display("[TB] FAIL rmc_launch: got %b want %b", ctrl, LAUNCH);
    end
    next_cycle();
    next_cycle();
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if ({ctrl, stall_cnt} !== {FREEZE, 8'd0}) begin
      n_failed++; $display("[TB] FAIL rmc_in_reset: got %b/%0d want %b/0", ctrl, stall_cnt, FREEZE);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_compared++;
    if (ctrl !== LAUNCH) begin
      n_failed++; $display("[TB] FAIL rmc_relaunch: got %b want %b", ctrl, LAUNCH);
    end
    next_cycle();
    mc_done = 1'b1;
    next_cycle();
    mc_done = 1'b0;
    @(negedge clk);
    n_compared++;
    if (ctrl !== ALL_LOAD) begin
      n_failed++; $display("[TB] FAIL rmc_advance: got %b want %b", ctrl, ALL_LOAD);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    bit mc_busy, mc_finished, mem_wait, hazard;
    int e_stall, e_bubble, e_flush;
    logic [7:0] want;
    do_reset();
    mc_busy = 0; mc_finished = 0;
    e_stall = 0; e_bubble = 0; e_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      id_to_ex_mem_read = $urandom % 2;
      id_to_ex_rd       = 5'($urandom % 4);
      if_to_id_rs1      = 5'($urandom % 4);
      if_to_id_rs2      = 5'($urandom % 4);
      if_to_id_use_rs1  = $urandom % 2;
      if_to_id_use_rs2  = $urandom % 2;
      imem_req          = ($urandom % 4) == 0;
      imem_resp         = $urandom % 2;
      dmem_req          = ($urandom % 4) == 0;
      dmem_resp         = $urandom % 2;
      ex_br_taken       = ($urandom % 5) == 0;
      ex_mc_op          = ($urandom % 8) == 0;
      mc_done           = ($urandom % 4) == 0;

      mem_wait = (imem_req && !imem_resp) || (dmem_req && !dmem_resp);
      hazard = id_to_ex_mem_read && id_to_ex_rd != 0 &&
               ((if_to_id_use_rs1 && id_to_ex_rd == if_to_id_rs1) ||
                (if_to_id_use_rs2 && id_to_ex_rd == if_to_id_rs2));

      @(negedge clk);
      n_compared++;
      if ({stall_cnt, bubble_cnt, flush_cnt} !== {8'(e_stall), 8'(e_bubble), 8'(e_flush)}) begin
        n_failed++;
        $display("[TB] FAIL rand_cnt_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 stall_cnt, bubble_cnt, flush_cnt, e_stall, e_bubble, e_flush);
      end

      // The mc op in EX occupies the pipe from launch until the first
      // unstalled cycle after its result is ready.
      if (mc_busy || mem_wait) begin
        want = FREEZE;
        e_stall = (e_stall < CNT_MAX) ? e_stall + 1 : CNT_MAX;
        if (mc_busy && mc_done) begin
          mc_busy = 0; mc_finished = 1;
        end
      end else if (mc_finished) begin
        want = ALL_LOAD;
        mc_finished = 0;
      end else if (ex_mc_op) begin
        want = LAUNCH;
        mc_busy = 1;
        e_stall = (e_stall < CNT_MAX) ? e_stall + 1 : CNT_MAX;
      end else if (ex_br_taken) begin
        want = REDIRECT;
        e_flush = (e_flush < CNT_MAX) ? e_flush + 1 : CNT_MAX;
      end else if (hazard) begin
        want = BUBBLE;
        e_bubble = (e_bubble < CNT_MAX) ? e_bubble + 1 : CNT_MAX;
      end else begin
        want = ALL_LOAD;
      end

      n_compared++;
      if (ctrl !== want) begin
        n_failed++; $display("[TB] FAIL rand_ctrl_%0d: got %b want %b", i, ctrl, want);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_bubble();
    test_imem_stall();
    test_branch_vs_load_use();
    test_mc_op();
    test_saturation();
    test_reset_mid_mc();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central hazard and stall controller for the 5-stage RV32I pipeline. Each cycle it decides which pipeline registers load, hold or take a bubble. Its inputs are load-use hazards that forwarding cannot cover, instruction and data cache miss handshakes, taken branches resolved in EX, and multi-cycle EX operations such as mul/div. It also keeps saturating performance counters for stall, bubble and flush events.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- id_to_ex_mem_read  in  1  instruction in EX is a load
- id_to_ex_rd  in  5  destination register of instruction in EX
- if_to_id_rs1, if_to_id_rs2  in  5 each  source registers of instruction in ID
- if_to_id_use_rs1, if_to_id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- imem_req, imem_resp  in  1 each  I-cache request outstanding / response this cycle
- dmem_req, dmem_resp  in  1 each  D-cache request (read or write) from MEM / response this cycle
- ex_br_taken  in  1  branch or jump in EX redirects the PC
- ex_mc_op  in  1  instruction in EX is multi-cycle
- mc_done  in  1  one-cycle pulse from the multi-cycle unit when its result is ready
- mc_start  out  1  one-cycle pulse that launches the multi-cycle unit
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  register load enables
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP, load_regfile=0) instead of the upstream value
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
Combinational terms:
- mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp)
- load_use = id_to_ex_mem_read & id_to_ex_rd≠0 & ((use_rs1 & rd==rs1) | (use_rs2 & rd==rs2))

FSM states: RUN, MC_WAIT, MC_HOLD. Decision priority, highest first:
1. **Global freeze.** Applies when mem_stall is true or state is MC_WAIT. All five load enables are 0 and both flushes are 0.
2. **Multi-cycle launch.** In RUN with ex_mc_op:
   - mc_start=1 and all loads=0.
   - Next state is MC_WAIT.
3. **Branch redirect.** Applies to ex_br_taken when neither of the above holds:
   - All loads=1.
   - if_id_flush=1 and id_ex_flush=1.
   - The branch wins over load_use in the same cycle.
4. **Load-use.**
   - pc_load=0 and if_id_load=0.
   - id_ex_load=1 with id_ex_flush=1, which inserts exactly one bubble.
   - ex_mem_load=1 and mem_wb_load=1.
5. **Otherwise** all loads=1 and both flushes=0.

Transitions:
- In MC_WAIT, mc_done moves the FSM to RUN if mem_stall=0, else to MC_HOLD. That cycle still has all loads=0.
- In MC_HOLD, mc_start is never reasserted. When mem_stall=0, all loads=1 so the mc instruction advances, and the FSM returns to RUN.
- mc_done seen in RUN or MC_HOLD is ignored.

Counters:
- stall_cnt increments on every cycle where rule 1 or rule 2 applies.
- bubble_cnt increments on every load-use bubble.
- flush_cnt increments on every redirect.
- All three saturate at all-ones and never wrap.

Reset: state=RUN and all counters=0. While rst is high, all loads, flushes and mc_start are forced to 0.

## Timing
- State and counters are registered. All control outputs are combinational (Mealy) from the current state and inputs.
- A load-use hazard costs exactly 1 cycle. The following cycle the load is in MEM, and forwarding covers the dependency.
- A multi-cycle op costs N+1 cycles, where N is the number of cycles from mc_start to mc_done inclusive, plus any overlapping mem_stall.
- mc_start is high for exactly one cycle per multi-cycle instruction.
- Redirect is a zero-wait action. PC, IF/ID and ID/EX update on the same edge.
- Counters show an event on the clock edge after the event cycle.
- If reset is asserted mid-MC_WAIT, the FSM returns to RUN immediately. The multi-cycle unit is reset by the same rst.

## Structure
- Add to the shared rv32i_types package: the pipe_ctrl_state_t enum {RUN, MC_WAIT, MC_HOLD}.
- One sub-module, sat_counter: parameterised width, inc input, saturating. It is instantiated three times.

## Test plan
- lw x5 in EX, ID reads x5 via rs2 with use_rs2=1 → one cycle with pc_load=0, if_id_load=0, id_ex_flush=1. The next cycle has all loads=1, and bubble_cnt=1.
- Same as above but id_to_ex_rd=0, or use_rs2=0 → no bubble.
- imem_req=1 with imem_resp low for 3 cycles, then high → all loads=0 for 3 cycles, loads=1 on the resp cycle, stall_cnt=3.
- ex_br_taken=1 together with load_use=1 → if_id_flush=1, id_ex_flush=1, pc_load=1; flush_cnt=1 and bubble_cnt unchanged.
- ex_mc_op=1 with mc_done 4 cycles after mc_start, and dmem stalled 2 cycles beyond mc_done → FSM goes RUN→MC_WAIT→MC_HOLD→RUN. mc_start pulses exactly once. Loads go to 1 on the first cycle with dmem_resp.
- Preload stall_cnt to all-ones by forcing it, then stall one more cycle → the counter holds all-ones. Assert rst mid-MC_WAIT → state=RUN, counters=0.
